// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        RECV,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into one 32-bit instruction word
// and flags the byte that completes it.
module byte_assembler
    import loader_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            accept,
    input  logic [$clog2(WORD_BYTES)-1:0]   byte_idx,
    input  logic [7:0]                      data,
    output logic [WORD_BYTES*8-1:0]         word_c,
    output logic                            last_c
);

    localparam int unsigned WW  = WORD_BYTES * 8;
    localparam int unsigned BIW = $clog2(WORD_BYTES);

    logic [WW-1:0] word;

    // Current word with the byte being accepted this cycle merged in.
    always_comb begin
        word_c = word;
        if (accept) begin
            word_c[8*byte_idx +: 8] = data;
        end
    end

    assign last_c = accept && (byte_idx == BIW'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else begin
            word <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a length-prefixed byte stream
// and holds the core until the program is in. Optional LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned NUM_INST = 128,
    parameter int unsigned TIMEOUT  = 4096,
    localparam int unsigned AW      = $clog2(NUM_INST)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    localparam int unsigned TW  = $clog2(TIMEOUT + 2);
    localparam int unsigned BIW = $clog2(WORD_BYTES);
    localparam int unsigned LW  = HDR_BYTES * 8;

    loader_state_t  state;
    logic [LW-1:0]  len;
    logic [BIW-1:0] byte_idx;
    logic [TW-1:0]  tmo_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
`endif

    logic           accept_c;
    logic           restart_c;
    logic           tmo_state_c;
    logic           tmo_hit_c;
    logic           asm_clr_c;
    logic           last_c;
    logic           last_word_c;
    logic [31:0]    word_c;
    logic [LW-1:0]  hdr_len_c;

    assign accept_c    = rx_valid && rx_ready;
    assign restart_c   = start && (state == IDLE || state == DONE || state == ERR);
    assign hdr_len_c   = {rx_data, len[7:0]};
    assign last_word_c = (len == LW'(words_loaded) + LW'(1));
    assign asm_clr_c   = restart_c || (state == ERR);

`ifdef LOADER_CHECKSUM_EN
    assign tmo_state_c = (state == HDR1) || (state == RECV) || (state == CHK);
`else
    assign tmo_state_c = (state == HDR1) || (state == RECV);
`endif

    // TIMEOUT == 0 never fires; otherwise fires on the TIMEOUT-th idle cycle.
    assign tmo_hit_c = (TIMEOUT != 0) && tmo_state_c && !accept_c
                       && (tmo_cnt == TW'(TIMEOUT - 1));

    byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr_c),
        .accept   (accept_c && (state == RECV)),
        .byte_idx (byte_idx),
        .data     (rx_data),
        .word_c   (word_c),
        .last_c   (last_c)
    );

    // Idle-cycle counter between accepted bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (tmo_state_c && !accept_c && !tmo_hit_c) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            core_hold    <= 1'b1;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= HDR0;
                        rx_ready     <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                end

                HDR0: begin
                    if (accept_c) begin
                        len[7:0] <= rx_data;
                        state    <= HDR1;
                    end
                end

                HDR1: begin
                    if (accept_c) begin
                        len <= hdr_len_c;
                        if (hdr_len_c == '0 || hdr_len_c > LW'(NUM_INST)) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state    <= RECV;
                            byte_idx <= '0;
                        end
                    end else if (tmo_hit_c) begin
                        state    <= ERR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end
                end

                RECV: begin
                    if (accept_c) begin
                        byte_idx <= byte_idx + BIW'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        // Completing byte: issue the write straight from the merged word.
                        if (last_c) begin
                            state      <= WRITE;
                            rx_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_waddr <= words_loaded[AW-1:0];
                            imem_wdata <= word_c;
                        end
                    end else if (tmo_hit_c) begin
                        state    <= ERR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end
                end

                WRITE: begin
                    words_loaded <= words_loaded + (AW+1)'(1);
                    byte_idx     <= '0;
                    if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= CHK;
                        rx_ready <= 1'b1;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
`endif
                    end else begin
                        state    <= RECV;
                        rx_ready <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept_c) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end else if (tmo_hit_c) begin
                        state    <= ERR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
